// File: rtl/serial_tx.sv
// Start/data(LSB first)/stop frame transmitter; frame length is (WIDTH+2)*CLKS_PER_BIT cycles from acceptance to done.
// Accepts a word only in IDLE (din_ready); din_valid at any other time is ignored.
module serial_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cyc_cnt, cyc_nxt;
  logic [BW-1:0]    bit_cnt, bit_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic             sout_nxt, busy_nxt, done_nxt;
  logic             cyc_end;

  assign din_ready = (state == IDLE);
  assign cyc_end   = (cyc_cnt == CYC_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cyc_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      sout    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cyc_cnt <= cyc_nxt;
      bit_cnt <= bit_nxt;
      shreg   <= shreg_nxt;
      sout    <= sout_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cyc_nxt   = cyc_cnt;
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    sout_nxt  = sout;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (din_valid && din_ready) begin
          state_nxt = START;
          shreg_nxt = din;
          cyc_nxt   = '0;
          bit_nxt   = '0;
          sout_nxt  = 1'b0;
          busy_nxt  = 1'b1;
        end
      end
      START: begin
        if (cyc_end) begin
          state_nxt = DATA;
          cyc_nxt   = '0;
          bit_nxt   = '0;
          sout_nxt  = shreg[0];
          shreg_nxt = shreg >> 1;
        end else begin
          cyc_nxt = cyc_cnt + 1'b1;
        end
      end
      DATA: begin
        if (cyc_end) begin
          cyc_nxt = '0;
          if (bit_cnt == BIT_LAST) begin
            state_nxt = STOP;
            sout_nxt  = 1'b1;
          end else begin
            bit_nxt   = bit_cnt + 1'b1;
            sout_nxt  = shreg[0];
            shreg_nxt = shreg >> 1;
          end
        end else begin
          cyc_nxt = cyc_cnt + 1'b1;
        end
      end
      STOP: begin
        // Return to IDLE with the line still high; done marks the IDLE cycle.
        if (cyc_end) begin
          state_nxt = IDLE;
          cyc_nxt   = '0;
          bit_nxt   = '0;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else begin
          cyc_nxt = cyc_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        sout_nxt  = 1'b1;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule
